// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a data port onto one single-port memory.
// Data wins by default; fetch is forced through after STARVE_MAX consecutive losses.
module mem_port_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_done,
  output logic [31:0]       if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [31:0]       dm_addr,
  input  logic [31:0]       dm_wdata,
  output logic              dm_done,
  output logic [31:0]       dm_rdata,
  output logic              dm_err,
  output logic              if_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              stall_if
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] starve_cnt;
  logic             own_if;
  logic             own_we;

  logic             any_req;
  logic             grant_if;
  logic [31:0]      win_addr;
  logic             win_we;
  logic             misalign;
  logic             unused_addr_hi;

  // Fetch wins when data is idle, or when it has lost too many times in a row.
  assign any_req        = if_req | dm_req;
  assign grant_if       = if_req & (~dm_req | (starve_cnt == STARVE_LIM));
  assign win_addr       = grant_if ? if_addr : dm_addr;
  assign win_we         = ~grant_if & dm_we;
  assign misalign       = |win_addr[1:0];
  assign unused_addr_hi = ^win_addr[31:ADDR_W+2];

  assign stall_if = if_req & ~if_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (any_req) state_nxt = misalign ? RESP : ACCESS;
      ACCESS:  if (mem_ack) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Memory-side outputs, done/err pulses and captured read data are all registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
      own_if     <= 1'b0;
      own_we     <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_done    <= 1'b0;
      dm_done    <= 1'b0;
      if_err     <= 1'b0;
      dm_err     <= 1'b0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
    end else begin
      if_done <= 1'b0;
      dm_done <= 1'b0;
      if_err  <= 1'b0;
      dm_err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (any_req) begin
            own_if <= grant_if;
            own_we <= win_we;
            if (grant_if)                        starve_cnt <= '0;
            else if (if_req && starve_cnt != STARVE_LIM) starve_cnt <= starve_cnt + 1'b1;
            if (misalign) begin
              if_done <= grant_if;
              if_err  <= grant_if;
              dm_done <= ~grant_if;
              dm_err  <= ~grant_if;
              if (grant_if) if_rdata <= '0;
              else          dm_rdata <= '0;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= win_we;
              mem_addr  <= win_addr[ADDR_W+1:2];
              mem_wdata <= grant_if ? 32'h0 : dm_wdata;
            end
          end
        end
        ACCESS: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (own_if) begin
              if_done  <= 1'b1;
              if_rdata <= mem_rdata;
            end else begin
              dm_done  <= 1'b1;
              dm_rdata <= own_we ? 32'h0 : mem_rdata;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic, checked by
// a transaction-level reference model feeding an expected-response queue.
module tb_mem_port_arbiter;
  localparam int ADDR_W     = 8;
  localparam int STARVE_MAX = 4;
  localparam int DEPTH      = 1 << ADDR_W;

  logic              clk, rst;
  logic              if_req, if_done, if_err, dm_req, dm_we, dm_done, dm_err;
  logic [31:0]       if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata;
  logic              mem_req, mem_we, mem_ack, stall_if;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata, mem_rdata;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_done(dm_done), .dm_rdata(dm_rdata), .dm_err(dm_err), .if_err(if_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall_if(stall_if)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { bit own_if; bit err; logic [31:0] rdata; int edge_n; } resp_t;
  typedef struct { int lat; logic [ADDR_W-1:0] addr; bit we; logic [31:0] wdata; } acc_t;

  resp_t       exp_q[$];
  acc_t        mq[$];
  bit          grant_q[$];
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] dev_mem [DEPTH];
  int          checks = 0, errors = 0;
  int          edge_cnt = 0, free_at = 0, starve = 0, force_lat = 0, mode = 0;
  logic [31:0] last_if = 0, last_dm = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom;
    a[ADDR_W+1:2] = ADDR_W'($urandom_range(0, DEPTH - 1));
    a[1:0] = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
    return a;
  endfunction

  // Reference model: one grant per free arbitration edge, priority decided from the
  // rules, completion edge derived from the access latency it hands to the memory.
  initial forever begin
    @(posedge clk);
    edge_cnt++;
    if (rst) begin
      exp_q.delete();
      mq.delete();
      starve  = 0;
      free_at = edge_cnt + 1;
    end else if (edge_cnt >= free_at && (if_req || dm_req)) begin
      bit          win_if;
      logic [31:0] a;
      resp_t       r;
      acc_t        m;
      win_if = if_req && (!dm_req || starve == STARVE_MAX);
      if (win_if) starve = 0;
      else if (if_req && starve < STARVE_MAX) starve++;
      a = win_if ? if_addr : dm_addr;
      r.own_if = win_if;
      r.err    = (a[1:0] != 2'b00);
      r.rdata  = 0;
      if (r.err) begin
        r.edge_n = edge_cnt;
        free_at  = edge_cnt + 2;
      end else begin
        m.lat   = (force_lat > 0) ? force_lat : $urandom_range(1, 5);
        m.addr  = a[ADDR_W+1:2];
        m.we    = !win_if && dm_we;
        m.wdata = dm_wdata;
        if (m.we) ref_mem[m.addr] = dm_wdata;
        else      r.rdata = ref_mem[m.addr];
        mq.push_back(m);
        r.edge_n = edge_cnt + m.lat;
        free_at  = edge_cnt + m.lat + 2;
      end
      exp_q.push_back(r);
      grant_q.push_back(win_if);
    end
  end

  // Memory device: acks in the lat-th cycle of an access, random ack noise otherwise.
  initial begin
    int   acnt;
    acc_t cur;
    acnt = 0;
    cur.lat = 1; cur.addr = 0; cur.we = 0; cur.wdata = 0;
    mem_ack = 1'b0;
    mem_rdata = 0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (rst) begin
        acnt = 0;
      end else if (mem_req) begin
        if (acnt == 0) begin
          if (mq.size() == 0) begin
            check("mem_req_unexpected", 32'(mem_req), 32'h0);
            cur.lat = 1; cur.addr = mem_addr; cur.we = mem_we; cur.wdata = mem_wdata;
          end else cur = mq.pop_front();
        end
        acnt++;
        if (acnt > cur.lat) check("mem_req_after_ack", 32'(mem_req), 32'h0);
        check("mem_addr", 32'(mem_addr), 32'(cur.addr));
        check("mem_we", 32'(mem_we), 32'(cur.we));
        if (cur.we) check("mem_wdata", mem_wdata, cur.wdata);
        if (acnt == cur.lat) begin
          mem_ack = 1'b1;
          if (mem_we) dev_mem[mem_addr] = mem_wdata;
          else        mem_rdata = dev_mem[mem_addr];
        end
      end else begin
        acnt = 0;
        mem_ack = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
      end
    end
  end

  // Monitor: compares every negedge against the head of the expected queue.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      check("rst_mem_req", 32'(mem_req), 32'h0);
      check("rst_pulses", {28'h0, if_done, dm_done, if_err, dm_err}, 32'h0);
      check("rst_rdata", if_rdata | dm_rdata, 32'h0);
      last_if = 0;
      last_dm = 0;
    end else begin
      bit due, e_ifd, e_dmd;
      while (exp_q.size() > 0 && exp_q[0].edge_n < edge_cnt) begin
        check("done_missing", 32'h0, 32'h1);
        void'(exp_q.pop_front());
      end
      due   = (exp_q.size() > 0) && (exp_q[0].edge_n == edge_cnt);
      e_ifd = due && exp_q[0].own_if;
      e_dmd = due && !exp_q[0].own_if;
      check("if_done", 32'(if_done), 32'(e_ifd));
      check("dm_done", 32'(dm_done), 32'(e_dmd));
      check("if_err", 32'(if_err), 32'(e_ifd && exp_q[0].err));
      check("dm_err", 32'(dm_err), 32'(e_dmd && exp_q[0].err));
      check("stall_if", 32'(stall_if), 32'(if_req && !e_ifd));
      if (e_ifd) last_if = exp_q[0].rdata;
      if (e_dmd) last_dm = exp_q[0].rdata;
      check("if_rdata", if_rdata, last_if);
      check("dm_rdata", dm_rdata, last_dm);
      if (due) void'(exp_q.pop_front());
    end
  end

  // Requester drivers: hold req until done; mode 1 re-requests at once, mode 2 randomly.
  initial begin
    if_req = 1'b0; if_addr = 0;
    forever begin
      @(negedge clk); #1;
      if (!rst) begin
        if (if_req && if_done) begin
          if (mode == 1) if_addr = rand_addr();
          else           if_req = 1'b0;
        end else if (!if_req && (mode == 1 || (mode == 2 && $urandom_range(0, 3) == 0))) begin
          if_req = 1'b1;
          if_addr = rand_addr();
        end
      end
    end
  end

  initial begin
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = 0; dm_wdata = 0;
    forever begin
      @(negedge clk); #1;
      if (!rst) begin
        if (dm_req && dm_done) begin
          if (mode == 1) begin
            dm_addr = rand_addr(); dm_we = 1'($urandom_range(0, 1)); dm_wdata = $urandom;
          end else dm_req = 1'b0;
        end else if (!dm_req && (mode == 1 || (mode == 2 && $urandom_range(0, 2) == 0))) begin
          dm_req = 1'b1;
          dm_addr = rand_addr(); dm_we = 1'($urandom_range(0, 1)); dm_wdata = $urandom;
        end
      end
    end
  end

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (!if_req && !dm_req) begin ok = 1'b1; break; end
    end
    check(name, 32'(ok), 32'h1);
    #2;
  endtask

  task automatic drive_if(input logic [31:0] a, input int lat);
    force_lat = lat;
    if_addr = a; if_req = 1'b1;
    wait_idle("if_directed_timeout");
  endtask

  task automatic drive_dm(input bit we, input logic [31:0] a, input logic [31:0] wd, input int lat);
    force_lat = lat;
    dm_we = we; dm_addr = a; dm_wdata = wd; dm_req = 1'b1;
    wait_idle("dm_directed_timeout");
  endtask

  initial begin
    bit seen;
    for (int i = 0; i < DEPTH; i++) begin
      dev_mem[i] = 32'(i) * 32'h0101_0101 ^ 32'hA5A5_0000;
      ref_mem[i] = dev_mem[i];
    end
    dev_mem[4] = 32'hDEADBEEF;
    ref_mem[4] = 32'hDEADBEEF;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_mem_bus", {mem_wdata[30:0] | 31'(mem_addr), mem_we}, 32'h0);
    check("reset_stall", 32'(stall_if), 32'h0);
    @(posedge clk); #2;
    rst = 1'b0;

    // directed: fetch, delayed store, misaligned load
    drive_if(32'h10, 1);
    drive_dm(1'b1, 32'h08, 32'h5, 4);
    check("store_landed", dev_mem[2], 32'h5);
    drive_dm(1'b0, 32'h06, 32'h0, 0);
    force_lat = 0;

    // both ports saturated: dm x STARVE_MAX then if, repeating
    grant_q.delete();
    mode = 1;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      if (grant_q.size() >= 15) break;
    end
    #2 mode = 0;
    check("sat_grant_count", 32'(grant_q.size() >= 15), 32'h1);
    for (int i = 0; i < 15 && i < grant_q.size(); i++)
      check($sformatf("sat_order_%0d", i), 32'(grant_q[i]), 32'(i % 5 == 4));
    wait_idle("sat_drain");

    // random traffic
    mode = 2;
    repeat (3000) @(posedge clk);
    #2 mode = 0;
    wait_idle("random_drain");

    // reset mid-access with a fetch pending
    force_lat = 6;
    dm_we = 1'b0; dm_addr = 32'h20; dm_req = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_req) begin seen = 1'b1; break; end
    end
    check("rst_scn_mem_req_seen", 32'(seen), 32'h1);
    #1 if_addr = 32'h44; if_req = 1'b1;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("rst_mid_mem_req", 32'(mem_req), 32'h0);
    check("rst_mid_done", {30'h0, if_done, dm_done}, 32'h0);
    dm_req = 1'b0;
    force_lat = 0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    wait_idle("rst_scn_if_served");

    // quiet period with memory ack noise
    repeat (30) @(posedge clk);
    check("final_queue_empty", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, giving the memory word-address width (256 words).
REQ-002 SHALL have parameter STARVE_MAX, default 4, giving the number of consecutive fetch losses allowed before fetch is forced to win.
REQ-003 SHALL have the following ports, one per line: name  direction  width  meaning.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- if_req  in  1  fetch request; held high until if_done.
- if_addr  in  32  fetch byte address.
- if_done  out  1  one-cycle pulse; the fetch access has completed.
- if_rdata  out  32  fetched word; valid while if_done is high.
- dm_req  in  1  data request; held high until dm_done.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  32  data byte address.
- dm_wdata  in  32  store data.
- dm_done  out  1  one-cycle pulse; the data access has completed.
- dm_rdata  out  32  load word; valid while dm_done is high.
- dm_err  out  1  one-cycle pulse; misaligned data address, access dropped.
- if_err  out  1  one-cycle pulse; misaligned fetch address, access dropped.
- mem_req  out  1  request to the shared single-port memory.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory word address.
- mem_wdata  out  32  memory write data.
- mem_ack  in  1  memory completion; latency of 1 or more cycles after mem_req.
- mem_rdata  in  32  memory read data; valid with mem_ack.
- stall_if  out  1  equals if_req and not if_done; drives the fetch-stage stall.

Function
REQ-004 SHALL implement an FSM with three states: IDLE, ACCESS and RESP.
REQ-005 IDLE: SHALL arbitrate when if_req or dm_req is high.
- The winner's address, we and wdata SHALL be latched, together with the owner.
- The FSM SHALL move to ACCESS on the next edge.
- With no request, the FSM SHALL stay in IDLE.
REQ-006 The arbitration policy SHALL be as follows:
- dm wins by default.
- if wins when dm_req is low.
- if wins when starve_cnt equals STARVE_MAX and if_req is high, regardless of dm_req.
REQ-007 starve_cnt SHALL behave as follows:
- Increment, saturating at STARVE_MAX, on each IDLE arbitration where if_req is high and dm wins.
- Clear to 0 when if wins.
- Otherwise hold.
REQ-008 Alignment checking: a winning address with addr[1:0] not equal to 0 SHALL NOT access memory.
- The FSM SHALL go IDLE to RESP directly.
- The owner's err output SHALL pulse in RESP; the owner's done output SHALL also pulse; rdata SHALL be 0.
REQ-009 ACCESS: SHALL hold mem_req=1, with mem_we, mem_addr=latched addr[ADDR_W+1:2] and mem_wdata stable.
- The FSM SHALL wait for mem_ack with no timeout.
- On mem_ack, the FSM SHALL capture mem_rdata (loads and fetches only) and move to RESP.
REQ-010 mem_req, mem_we, mem_addr and mem_wdata SHALL be registered outputs; mem_req SHALL be 1 only in ACCESS.
REQ-011 RESP: SHALL pulse only the owner's done output for exactly one cycle, with the captured rdata, then return to IDLE.
- New arbitration SHALL occur no earlier than the IDLE cycle that follows.
REQ-012 Store completion: dm_rdata SHALL be 0 on dm_done for a store.
REQ-013 mem_ack sampled outside ACCESS SHALL be ignored.
REQ-014 Minimum occupancy SHALL be 3 cycles per access (IDLE, ACCESS, RESP) with a 1-cycle memory; the latency from request sampled to done SHALL be 2 + memory latency cycles.
REQ-015 Request withdrawal: a request dropped before done is illegal; the arbiter SHALL complete the latched access regardless.
REQ-016 if_rdata and dm_rdata SHALL hold their last value outside done pulses.

Reset
REQ-017 While rst=1, the block SHALL immediately force the following, including mid-access:
- state IDLE, starve_cnt 0, mem_req 0, mem_we 0;
- mem_addr 0, mem_wdata 0;
- if_done, dm_done, if_err and dm_err 0;
- if_rdata and dm_rdata 0.
REQ-018 An access interrupted by reset SHALL be abandoned without a done pulse; arbitration SHALL resume in the first cycle after rst falls.

Verification
REQ-019 The bench SHALL cover the following directed scenarios:
- if_req only, if_addr=0x10, mem_ack 1 cycle after mem_req, mem_rdata=0xDEADBEEF -> mem_addr=4; if_done pulses 3 cycles after the request with if_rdata=0xDEADBEEF; dm_done stays 0.
- dm store dm_addr=0x08, dm_wdata=5, mem_ack delayed 4 cycles -> mem_we=1, mem_addr=2 and mem_wdata=5 held for 4 cycles; a single dm_done pulse with dm_rdata=0.
- if_req and dm_req both held high continuously, STARVE_MAX=4 -> grant order dm,dm,dm,dm,if, repeating; stall_if high throughout each waiting period.
- dm_addr=0x06 -> no mem_req; dm_err and dm_done pulse together 2 cycles later.
- rst asserted while in ACCESS -> mem_req drops immediately; no done pulse; after release, a pending if_req is served normally.
- mem_ack held high in IDLE with no requests -> no state change and no outputs.
